// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write side of the Yu Core instruction memory. A byte stream arriving over a
// valid/ready handshake is packed little-endian into 32-bit instruction words.
// Each word goes to the instruction-memory write port at consecutive word
// addresses. The core is held in reset for as long as a load is in progress.
//
// Optional feature (compile-time macro): IMEM_LOADER_CHECKSUM_EN
//   defined   : `checksum` is the XOR of every word written by the current load.
//               It is cleared on an accepted start and is valid from `done`
//               until the next start.
//   undefined : `checksum` is tied to zero and no accumulator exists.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   start          in   single-cycle load request (only honoured in IDLE)
//   baseAddr       in   first byte address; bits [1:0] are forced to zero
//   wordCount      in   number of words to load, latched on start
//   byteData       in   incoming byte
//   byteValid      in   byteData is valid
//   byteReady      out  loader accepts a byte this cycle
//   memWriteEnable out  instruction-memory write strobe (one cycle per word)
//   memAddr        out  write byte address
//   memWriteData   out  word to write
//   busy           out  load in progress (COLLECT, WRITE, DONE)
//   done           out  one-cycle pulse when a load completes
//   coreHold       out  holds the core in reset; equal to busy
//   checksum       out  running XOR of written words (see above)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  baseAddr,
    input  logic [COUNT_WIDTH-1:0] wordCount,
    input  logic [7:0]             byteData,
    input  logic                   byteValid,
    output logic                   byteReady,
    output logic                   memWriteEnable,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    output logic [DATA_WIDTH-1:0]  memWriteData,
    output logic                   busy,
    output logic                   done,
    output logic                   coreHold,
    output logic [DATA_WIDTH-1:0]  checksum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // Masking (rather than slicing) keeps every baseAddr bit in use while
    // forcing word alignment.
    localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0]  WORD_STRIDE = ADDR_WIDTH'(3'd4);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1'b1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;

    logic                   byte_ready_q, byte_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = baseAddr & ALIGN_MASK;
                    count_d = wordCount;
                    idx_d   = 2'd0;
                    word_d  = '0;
                    if (wordCount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                // byte_ready_q is high throughout COLLECT, so acceptance
                // never depends combinationally on byteValid for the ready.
                if (byteValid && byte_ready_q) begin
                    word_d[{idx_q, 3'b000} +: 8] = byteData;
                    if (idx_q == 2'd3) begin
                        state_d     = S_WRITE;
                        idx_d       = 2'd0;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = word_d;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_WRITE: begin
                // Address wraps naturally modulo 2^ADDR_WIDTH.
                addr_d  = addr_q + WORD_STRIDE;
                count_d = count_q - COUNT_ONE;
                if (count_q == COUNT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        byte_ready_d = (state_d == S_COLLECT);
        mem_we_d     = (state_d == S_WRITE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            idx_q        <= 2'd0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    // Checksum accumulation: cleared on an accepted start, folded in on WRITE.
    always_comb begin
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (state_q == S_WRITE) begin
            checksum_d = checksum_q ^ mem_wdata_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign byteReady      = byte_ready_q;
    assign memWriteEnable = mem_we_q;
    assign memAddr        = mem_addr_q;
    assign memWriteData   = mem_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign coreHold       = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. A reference model turns each requested load
// (base address, word count, byte list) into the list of (address, word)
// writes the loader must produce; a compare process checks every DUT write
// against that list on the falling edge. Literal expectations for selected
// loads pin the model itself.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] baseAddr = 32'h0;
    logic [15:0] wordCount = 16'h0;
    logic [7:0]  byteData = 8'h0;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic        memWriteEnable;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        busy;
    logic        done;
    logic        coreHold;
    logic [31:0] checksum;

    imem_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .COUNT_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .baseAddr      (baseAddr),
        .wordCount     (wordCount),
        .byteData      (byteData),
        .byteValid     (byteValid),
        .byteReady     (byteReady),
        .memWriteEnable(memWriteEnable),
        .memAddr       (memAddr),
        .memWriteData  (memWriteData),
        .busy          (busy),
        .done          (done),
        .coreHold      (coreHold),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_ck;
    logic [7:0]  feed[$];
    logic        prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: word j of the load lands at aligned base + 4*j (mod 2^32) and
    // is built from feed bytes 4j..4j+3, first byte least significant.
    task automatic expect_load(input logic [31:0] base, input int cnt);
        logic [31:0] a;
        logic [31:0] w;
        exp_ck = 32'h0;
        for (int j = 0; j < cnt; j++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * j);
            w = {feed[4*j+3], feed[4*j+2], feed[4*j+1], feed[4*j]};
            exp_addr.push_back(a);
            exp_data.push_back(w);
            exp_ck = exp_ck ^ w;
        end
    endtask

    function automatic logic [31:0] model_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        return exp_ck;
`else
        return 32'h0;
`endif
    endfunction

    // Compare process: every write against the model, plus write-cycle rules.
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            check("corehold_eq_busy", {31'h0, coreHold}, {31'h0, busy});
            if (memWriteEnable) begin
                check("ready_low_in_write", {31'h0, byteReady}, 32'h0);
                check("write_single_cycle", {31'h0, prev_we}, 32'h0);
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                             memAddr, memWriteData);
                end else begin
                    check("write_addr", memAddr, exp_addr.pop_front());
                    check("write_data", memWriteData, exp_data.pop_front());
                end
                log_addr.push_back(memAddr);
                log_data.push_back(memWriteData);
            end
            prev_we = memWriteEnable;
        end
    end

    task automatic check_log(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (log_addr.size() <= idx) begin
            checks++;
            failures++;
            $display("FAIL log_entry_missing: got %0d writes expected more than %0d", log_addr.size(), idx);
        end else begin
            check("pin_addr", log_addr[idx], a);
            check("pin_data", log_data[idx], d);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_byteReady"}, {31'h0, byteReady}, 32'h0);
        check({tag, "_memWE"}, {31'h0, memWriteEnable}, 32'h0);
        check({tag, "_memAddr"}, memAddr, 32'h0);
        check({tag, "_memData"}, memWriteData, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_coreHold"}, {31'h0, coreHold}, 32'h0);
        check({tag, "_checksum"}, checksum, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    // Pulse start; return at the falling edge of cycle N+1.
    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        @(negedge clk);
        start     = 1'b1;
        baseAddr  = base;
        wordCount = cnt;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_ready", {31'h0, byteReady}, {31'h0, (cnt != 16'h0)});
        check("start_done", {31'h0, done}, {31'h0, (cnt == 16'h0)});
    endtask

    // Offer feed bytes; inputs change only on falling edges.
    task automatic feed_bytes(input bit stall, input bit inject);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        bit  injected = 0;
        while (i < feed.size() && cyc < 400) begin
            start     = 1'b0;
            byteData  = feed[i];
            byteValid = stall ? ((cyc % 2) == 0) : 1'b1;
            if (inject && i == 2 && !injected) begin
                start     = 1'b1;
                baseAddr  = 32'h0000_0200;
                wordCount = 16'd5;
                injected  = 1;
            end
            acc = byteReady && byteValid;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        start     = 1'b0;
        byteValid = 1'b0;
        check("feed_complete", 32'(i), 32'(feed.size()));
    endtask

    task automatic wait_done(input logic [31:0] ck_exp);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("done_seen", {31'h0, seen}, 32'h1);
        if (seen) begin
            check("done_busy", {31'h0, busy}, 32'h1);
            check("writes_outstanding", 32'(exp_addr.size()), 32'h0);
            check("checksum", checksum, ck_exp);
            @(negedge clk);
            check("after_done_done", {31'h0, done}, 32'h0);
            check("after_done_busy", {31'h0, busy}, 32'h0);
            check("after_done_hold", {31'h0, coreHold}, 32'h0);
        end
    endtask

    task automatic set_basic_feed();
        feed = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("init");
        reset = 1'b0;

        // Basic load, valid held high
        set_basic_feed();
        log_addr.delete(); log_data.delete();
        expect_load(32'h0, 2);
        do_start(32'h0, 16'd2);
        feed_bytes(1'b0, 1'b0);
        wait_done(model_checksum());
        check_log(0, 32'h0000_0000, 32'h0010_0513);
        check_log(1, 32'h0000_0004, 32'h0020_0593);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("checksum_literal", checksum, 32'h0030_0080);
`else
        check("checksum_literal", checksum, 32'h0000_0000);
`endif

        // Handshake stalls: byteValid toggles every cycle
        set_basic_feed();
        log_addr.delete(); log_data.delete();
        expect_load(32'h0, 2);
        do_start(32'h0, 16'd2);
        feed_bytes(1'b1, 1'b0);
        wait_done(model_checksum());
        check("stall_write_count", 32'(log_addr.size()), 32'd2);
        check_log(1, 32'h0000_0004, 32'h0020_0593);

        // Alignment and address wrap
        feed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        log_addr.delete(); log_data.delete();
        expect_load(32'hFFFF_FFFE, 2);
        do_start(32'hFFFF_FFFE, 16'd2);
        feed_bytes(1'b0, 1'b0);
        wait_done(model_checksum());
        check_log(0, 32'hFFFF_FFFC, 32'h4433_2211);
        check_log(1, 32'h0000_0000, 32'h8877_6655);

        // Zero word count: done the cycle after start, no write
        log_addr.delete(); log_data.delete();
        exp_ck = 32'h0;
        do_start(32'h0000_0020, 16'd0);
        @(negedge clk);
        check("zero_done_low", {31'h0, done}, 32'h0);
        check("zero_busy_low", {31'h0, busy}, 32'h0);
        check("zero_checksum", checksum, model_checksum());
        check("zero_no_write", 32'(log_addr.size()), 32'h0);

        // Start mid-load is ignored
        set_basic_feed();
        log_addr.delete(); log_data.delete();
        expect_load(32'h0000_0080, 2);
        do_start(32'h0000_0080, 16'd2);
        feed_bytes(1'b0, 1'b1);
        wait_done(model_checksum());
        check("midstart_write_count", 32'(log_addr.size()), 32'd2);
        check_log(0, 32'h0000_0080, 32'h0010_0513);

        // Reset after two bytes: no write, then a clean one-word load
        feed = '{8'hAA, 8'hBB};
        log_addr.delete(); log_data.delete();
        do_start(32'h0000_0040, 16'd1);
        feed_bytes(1'b0, 1'b0);
        do_reset();
        check("partial_no_write", 32'(log_addr.size()), 32'h0);
        feed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expect_load(32'h0000_0010, 1);
        do_start(32'h0000_0010, 16'd1);
        feed_bytes(1'b0, 1'b0);
        wait_done(model_checksum());
        check_log(0, 32'h0000_0010, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
